// File: rtl/wildcard_addr_decoder.sv
// -----------------------------------------------------------------------------
// wildcard_addr_decoder
//
// Run-time programmable casez-style address decoder. Each of NUM_RULES rules
// holds a compare value, a care mask (1 = compare bit, 0 = don't-care) and an
// enable. An address matches rule i when the rule is enabled and every cared
// bit equals the rule value. The lowest matching index wins. The decode result
// goes through a one-entry registered output stage, and every accepted hit
// bumps a saturating per-rule hit counter for the winning rule.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// the transfer; ready may be used combinationally by the other side.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we/idx/value/
//   cfg_mask/cfg_en     rule table write port; out-of-range idx is ignored
//   in_valid/in_ready   address input handshake
//   in_addr             address to decode
//   out_valid/out_ready result output handshake
//   out_hit/idx/multi   result: any match, winning index (0 on miss),
//                       more than one match
//   cnt_rd_idx          hit counter select (out of range reads 0)
//   cnt_rd_data         combinational read of the selected hit counter
//   cnt_clr             synchronous clear of all hit counters
//   dbg_state           output stage state (0 = EMPTY, 1 = FULL)
// -----------------------------------------------------------------------------
module wildcard_addr_decoder #(
   parameter int ADDR_W    = 4,
   parameter int NUM_RULES = 4,
   parameter int CNT_W     = 8,
   localparam int IDX_W    = $clog2(NUM_RULES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_value,
   input  logic [ADDR_W-1:0] cfg_mask,
   input  logic              cfg_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_hit,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_multi,
   input  logic [IDX_W-1:0]  cnt_rd_idx,
   output logic [CNT_W-1:0]  cnt_rd_data,
   input  logic              cnt_clr,
   output logic              dbg_state
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Rule table
   logic [ADDR_W-1:0]    r_value [NUM_RULES];
   logic [ADDR_W-1:0]    r_mask  [NUM_RULES];
   logic [NUM_RULES-1:0] r_en;

   // Hit counters
   logic [CNT_W-1:0]     r_cnt   [NUM_RULES];

   // Output stage
   out_state_t           r_state;
   logic                 r_hit;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_multi;

   // Decode
   logic [NUM_RULES-1:0] w_match;
   logic                 w_hit;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_multi;
   logic                 w_accept;

   assign out_valid = (r_state == ST_FULL);
   assign out_hit   = r_hit;
   assign out_idx   = r_idx;
   assign out_multi = r_multi;
   assign dbg_state = r_state;

   // The slot frees up in the same cycle it is drained, giving full throughput.
   assign in_ready  = !out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;

   always_comb begin
      w_match = '0;
      for (int i = 0; i < NUM_RULES; i++) begin
         w_match[i] = r_en[i] && (((in_addr ^ r_value[i]) & r_mask[i]) == '0);
      end
   end

   // Priority pick: first match sets the index, any later match flags multi.
   always_comb begin
      w_hit   = 1'b0;
      w_idx   = '0;
      w_multi = 1'b0;
      for (int i = 0; i < NUM_RULES; i++) begin
         if (w_match[i]) begin
            if (w_hit) begin
               w_multi = 1'b1;
            end else begin
               w_idx = IDX_W'(i);
            end
            w_hit = 1'b1;
         end
      end
   end

   // Rule table write. The lookup above reads the current (pre-write) table,
   // so a lookup accepted alongside a write sees the old rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            r_value[i] <= '0;
            r_mask[i]  <= '0;
            r_en[i]    <= 1'b0;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               r_value[i] <= cfg_value;
               r_mask[i]  <= cfg_mask;
               r_en[i]    <= cfg_en;
            end
         end
      end
   end

   // Output stage FSM with registered result fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_hit   <= 1'b0;
         r_idx   <= '0;
         r_multi <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_state <= ST_FULL;
                  r_hit   <= w_hit;
                  r_idx   <= w_idx;
                  r_multi <= w_multi;
               end
            end
            ST_FULL: begin
               if (w_accept) begin
                  r_hit   <= w_hit;
                  r_idx   <= w_idx;
                  r_multi <= w_multi;
               end else if (out_ready) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   // Saturating hit counters; clear wins over a simultaneous increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (cnt_clr) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (w_accept && w_hit) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            if ((w_idx == IDX_W'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      cnt_rd_data = '0;
      for (int i = 0; i < NUM_RULES; i++) begin
         if (cnt_rd_idx == IDX_W'(i)) begin
            cnt_rd_data = r_cnt[i];
         end
      end
   end

endmodule

// File: tb/tb_wildcard_addr_decoder.sv
module tb_wildcard_addr_decoder;

  localparam int ADDR_W    = 4;
  localparam int NUM_RULES = 4;
  localparam int CNT_W     = 2;
  localparam int IDX_W     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_value = '0;
  logic [ADDR_W-1:0] cfg_mask = '0;
  logic              cfg_en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_hit;
  logic [IDX_W-1:0]  out_idx;
  logic              out_multi;
  logic [IDX_W-1:0]  cnt_rd_idx = '0;
  logic [CNT_W-1:0]  cnt_rd_data;
  logic              cnt_clr = 1'b0;
  logic              dbg_state;

  wildcard_addr_decoder #(
    .ADDR_W(ADDR_W), .NUM_RULES(NUM_RULES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_idx(out_idx), .out_multi(out_multi),
    .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data), .cnt_clr(cnt_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard + reference model ----------------
  // Expected result packed as {hit, idx[1:0], multi}.
  logic [3:0] exp_q[$];
  int total = 0;
  int bad = 0;

  logic [3:0] m_val  [NUM_RULES];
  logic [3:0] m_mask [NUM_RULES];
  logic       m_en   [NUM_RULES];
  int         m_cnt  [NUM_RULES];
  logic       m_full;
  logic       seen_rdy;
  logic       exp_rdy;

  function automatic logic [3:0] model(input logic [3:0] a);
    logic       hit;
    logic [1:0] idx;
    int         n;
    hit = 1'b0;
    idx = 2'd0;
    n   = 0;
    // Scan from the top so the lowest matching index is the one kept.
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (m_en[i] && (((a ^ m_val[i]) & m_mask[i]) == 4'd0)) begin
        hit = 1'b1;
        idx = i[1:0];
        n++;
      end
    end
    return {hit, idx, (n > 1)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_RULES; i++) begin
      m_val[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0; m_cnt[i] = 0;
    end
    m_full = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle starting just after a rising edge; returns 1 time unit
  // after the next rising edge. Scoreboard/model follow the handshake.
  task automatic drive(input logic v, input logic [3:0] a, input logic rdy,
                       input logic we, input logic [1:0] ci, input logic [3:0] cv,
                       input logic [3:0] cm, input logic ce, input logic clr);
    logic [3:0] res;
    logic       acc;
    in_valid = v; in_addr = a; out_ready = rdy;
    cfg_we = we; cfg_idx = ci; cfg_value = cv; cfg_mask = cm; cfg_en = ce;
    cnt_clr = clr;
    res     = model(a);
    exp_rdy = !m_full || rdy;
    acc     = v && exp_rdy;
    #2;
    seen_rdy = in_ready;
    if (m_full && rdy) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(res);
    if (acc) m_full = 1'b1;
    else if (rdy) m_full = 1'b0;
    if (clr) begin
      for (int i = 0; i < NUM_RULES; i++) m_cnt[i] = 0;
    end else if (acc && res[3] && (m_cnt[int'(res[2:1])] != 3)) begin
      m_cnt[int'(res[2:1])]++;
    end
    if (we) begin
      m_val[ci] = cv; m_mask[ci] = cm; m_en[ci] = ce;
    end
    @(posedge clk);
    #1;
    cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic lookup(input logic v, input logic [3:0] a, input logic rdy);
    drive(v, a, rdy, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input logic [1:0] ci, input logic [3:0] cv,
                           input logic [3:0] cm, input logic ce);
    drive(1'b0, 4'd0, 1'b1, 1'b1, ci, cv, cm, ce, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if ({out_hit, out_idx, out_multi} !== 4'b0000) begin bad++; $display("FAIL reset out fields: got %b want 0000", {out_hit, out_idx, out_multi}); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset dbg_state: got %b want 0", dbg_state); end
    rst_n = 1'b1;
    for (int i = 0; i < NUM_RULES; i++) begin
      cnt_rd_idx = i[1:0];
      #1;
      total++; if (cnt_rd_data !== 2'd0) begin bad++; $display("FAIL reset cnt[%0d]: got %0d want 0", i, cnt_rd_data); end
    end
    cnt_rd_idx = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [3:0] addrs [5];
    addrs = '{4'b1011, 4'b1010, 4'b0011, 4'b1111, 4'b0000};
    cfg_write(2'd0, 4'b1010, 4'b1110, 1'b1);
    cfg_write(2'd1, 4'b0010, 4'b1110, 1'b1);
    for (int k = 0; k < 5; k++) begin
      // last entry is an idle cycle that drains the final result
      lookup(k < 4, addrs[k], 1'b1);
      total++; if (seen_rdy !== exp_rdy) begin bad++; $display("FAIL basic in_ready[%0d]: got %b want %b", k, seen_rdy, exp_rdy); end
      total++; if (out_valid !== m_full) begin bad++; $display("FAIL basic out_valid[%0d]: got %b want %b", k, out_valid, m_full); end
      if (m_full) begin
        total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL basic result[%0d]: got %b want %b", k, {out_hit, out_idx, out_multi}, exp_q[0]); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_overlap();
    logic [3:0] addrs [3];
    addrs = '{4'b1011, 4'b1111, 4'b0000};
    cfg_write(2'd2, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      lookup(k < 2, addrs[k], 1'b1);
      total++; if (out_valid !== m_full) begin bad++; $display("FAIL overlap out_valid[%0d]: got %b want %b", k, out_valid, m_full); end
      if (m_full) begin
        total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL overlap result[%0d]: got %b want %b", k, {out_hit, out_idx, out_multi}, exp_q[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] held;
    lookup(1'b1, 4'b1011, 1'b0);
    held = {out_hit, out_idx, out_multi};
    total++; if (held !== exp_q[0]) begin bad++; $display("FAIL bp first: got %b want %b", held, exp_q[0]); end
    // 0011 waits on the input while the output is stalled
    for (int k = 0; k < 3; k++) begin
      lookup(1'b1, 4'b0011, 1'b0);
      total++; if (seen_rdy !== 1'b0) begin bad++; $display("FAIL bp in_ready[%0d]: got %b want 0", k, seen_rdy); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid[%0d]: got %b want 1", k, out_valid); end
      total++; if ({out_hit, out_idx, out_multi} !== held) begin bad++; $display("FAIL bp stable[%0d]: got %b want %b", k, {out_hit, out_idx, out_multi}, held); end
    end
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL bp queue: got %0d want 1", exp_q.size()); end
    lookup(1'b1, 4'b0011, 1'b1);
    total++; if (seen_rdy !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got %b want 1", seen_rdy); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp second valid: got %b want 1", out_valid); end
    total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL bp second: got %b want %b", {out_hit, out_idx, out_multi}, exp_q[0]); end
    lookup(1'b0, 4'b0000, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp drain: got %b want 0", out_valid); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_counters();
    cnt_rd_idx = 2'd0;
    drive(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    total++; if (cnt_rd_data !== 2'd0) begin bad++; $display("FAIL cnt cleared: got %0d want 0", cnt_rd_data); end
    for (int k = 0; k < 5; k++) begin
      lookup(1'b1, 4'b1011, 1'b1);
      total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL cnt result[%0d]: got %b want %b", k, {out_hit, out_idx, out_multi}, exp_q[0]); end
      total++; if (int'(cnt_rd_data) != m_cnt[0]) begin bad++; $display("FAIL cnt step[%0d]: got %0d want %0d", k, cnt_rd_data, m_cnt[0]); end
    end
    total++; if (cnt_rd_data !== 2'd3) begin bad++; $display("FAIL cnt saturate: got %0d want 3", cnt_rd_data); end
    cnt_rd_idx = 2'd2;
    #1;
    total++; if (int'(cnt_rd_data) != m_cnt[2]) begin bad++; $display("FAIL cnt nonwinner: got %0d want %0d", cnt_rd_data, m_cnt[2]); end
    cnt_rd_idx = 2'd0;
    // sixth hit accepted on the same edge as the clear
    drive(1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    total++; if (cnt_rd_data !== 2'd0) begin bad++; $display("FAIL cnt clr wins: got %0d want 0", cnt_rd_data); end
    lookup(1'b0, 4'b0000, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cnt drain: got %b want 0", out_valid); end
  endtask

  task automatic test_write_during_lookup();
    drive(1'b1, 4'b1011, 1'b1, 1'b1, 2'd0, 4'b1010, 4'b1110, 1'b0, 1'b0);
    total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL wdl pre-write: got %b want %b", {out_hit, out_idx, out_multi}, exp_q[0]); end
    total++; if (out_idx !== 2'd0) begin bad++; $display("FAIL wdl pre-write idx: got %0d want 0", out_idx); end
    lookup(1'b1, 4'b1011, 1'b1);
    total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL wdl post-write: got %b want %b", {out_hit, out_idx, out_multi}, exp_q[0]); end
    total++; if (out_idx !== 2'd2) begin bad++; $display("FAIL wdl post-write idx: got %0d want 2", out_idx); end
    lookup(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      lookup(1'b1, 4'($urandom_range(0, 15)), 1'b1);
      total++; if ({out_hit, out_idx, out_multi} !== exp_q[0]) begin bad++; $display("FAIL rnd result[%0d]: got %b want %b", k, {out_hit, out_idx, out_multi}, exp_q[0]); end
    end
    lookup(1'b1, 4'b1111, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst pre valid: got %b want 1", out_valid); end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst async valid: got %b want 0", out_valid); end
    total++; if ({out_hit, out_idx, out_multi} !== 4'b0000) begin bad++; $display("FAIL rst async fields: got %b want 0000", {out_hit, out_idx, out_multi}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst in_ready: got %b want 1", in_ready); end
    lookup(1'b1, 4'b1011, 1'b1);
    total++; if ({out_hit, out_idx, out_multi} !== 4'b0000) begin bad++; $display("FAIL rst lookup: got %b want 0000", {out_hit, out_idx, out_multi}); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst lookup valid: got %b want 1", out_valid); end
    for (int i = 0; i < NUM_RULES; i++) begin
      cnt_rd_idx = i[1:0];
      #1;
      total++; if (cnt_rd_data !== 2'd0) begin bad++; $display("FAIL rst cnt[%0d]: got %0d want 0", i, cnt_rd_data); end
    end
    @(posedge clk); #1;
    lookup(1'b0, 4'b0000, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst drain: got %b want 0", out_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_back_to_back();
    test_counters();
    test_write_during_lookup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wildcard_addr_decoder.md
# wildcard_addr_decoder

Programmable wildcard address decoder: compares each incoming address against NUM_RULES rules, each with a value and a care mask (mask bit 0 = don't-care, the runtime equivalent of a `z` bit in a `casez` item). The lowest-index matching rule wins. Result is delivered through a registered valid/ready output stage, and per-rule saturating hit counters are maintained. It sits between an address source and downstream select logic wherever casez-style decoding must be reconfigurable at run time.

## Interface
- ADDR_W, 4, address and rule width in bits (≥1)
- NUM_RULES, 4, number of rules (≥2); IDX_W = $clog2(NUM_RULES)
- CNT_W, 8, hit counter width in bits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_we  in  1  rule write strobe
- cfg_idx  in  IDX_W  rule index to write; values ≥ NUM_RULES are ignored
- cfg_value  in  ADDR_W  rule compare value
- cfg_mask  in  ADDR_W  care mask (1 = compare bit, 0 = don't-care)
- cfg_en  in  1  rule enable
- in_valid  in  1  address valid
- in_ready  out  1  decoder can accept
- in_addr  in  ADDR_W  address to decode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_hit  out  1  at least one enabled rule matched
- out_idx  out  IDX_W  winning rule index; 0 on miss
- out_multi  out  1  more than one enabled rule matched
- cnt_rd_idx  in  IDX_W  counter select; values ≥ NUM_RULES read as 0
- cnt_rd_data  out  CNT_W  combinational read of the selected hit counter
- cnt_clr  in  1  synchronous clear of all hit counters

## Operation
- Rule i matches when en_i = 1 and ((in_addr ^ value_i) & mask_i) == 0. A mask of 0 matches every address.
- Priority: lowest matching index drives out_idx. out_multi = popcount(matches) > 1.
- Acceptance: in_valid && in_ready. in_ready = !out_valid || out_ready. Full throughput, one address per cycle.
- Output register has two states. EMPTY → FULL on acceptance. FULL → EMPTY on out_ready without acceptance. FULL stays FULL on out_ready with acceptance (new result loaded). FULL holds without out_ready, and out_* stay stable.
- Config write: on cfg_we, rule cfg_idx takes {cfg_value, cfg_mask, cfg_en} at the clock edge. A lookup accepted in the same cycle uses the pre-write table.
- Counters: on acceptance with a hit, counter[winner] increments and saturates at 2^CNT_W−1. Misses and non-winning matches do not count. cnt_clr zeroes all counters. On the same edge, cnt_clr overrides any increment.
- Reset, any time including mid-transaction:
  - all rules become value=0, mask=0, en=0;
  - counters become 0;
  - out_valid, out_hit, out_multi, out_idx become 0;
  - a pending result is discarded;
  - in_ready = 1 on the first edge after release.

## Timing
- Latency: the result is visible one cycle after acceptance.
- No combinational path from in_addr or in_valid to out_*. in_ready depends combinationally on out_ready only.
- Rule or counter update is visible to a lookup or to cnt_rd_data on the cycle after the write edge.
- Counter wrap-around never occurs. A counter at its maximum stays at its maximum.

## Test plan
- Rules: r0 = value 1010, mask 1110, en; r1 = value 0010, mask 1110, en. Addresses 1011, 1010, 0011, 1111 → (hit, idx, multi) = (1,0,0), (1,0,0), (1,1,0), (0,0,0), each one cycle after acceptance.
- Overlap: add r2 = mask 0000, en. Address 1011 → hit=1, idx=0, multi=1. Address 1111 → hit=1, idx=2, multi=0.
- Backpressure: hold out_ready=0 and present 1011 then 0011 back-to-back. First result is held stable and in_ready=0. Raise out_ready → 1011 result consumed, then 0011 result appears. No loss, no duplication.
- Counters with CNT_W=2: five accepted hits on r0 → cnt_rd_data(0) = 3. Assert cnt_clr in the same cycle as a sixth hit is accepted → counter reads 0 next cycle.
- Write-during-lookup: accept 1011 while writing r0.en=0 → result idx=0. Next lookup of 1011 → idx=2 (r2 still enabled).
- Reset mid-operation: with out_valid=1 and out_ready=0, pulse rst_n low asynchronously → out_valid=0 immediately and in_ready=1 after release. Address 1011 → hit=0, all counters 0.
